branch_redirect: RTL and testbench
==================================

// Module: branch_redirect
// PURPOSE
//  Consumes the branch_resolved_t produced by the ID-stage branch resolver and compares it to the fetch-time prediction.
//  On mispredict it waits until the MIPS delay slot is in the pipe, then emits a one-cycle redirect and flush to fetch.
//  Every resolved branch is queued in a small FIFO that drains into the predictor as BTB/BHT update requests.
//  Sits between ID-stage branch resolution and IF-stage PC selection / branch predictor.
// PARAMETERS
//  UPD_DEPTH  4   predictor-update FIFO depth; power of two, >=2
// PORTS
//  clk              in   1   core clock
//  rst_n            in   1   asynchronous, active-low reset
//  stall            in   1   ID stage held this cycle; no acceptance while high
//  except_flush     in   1   exception/ERET flush; highest priority
//  resolved_branch  in   branch_resolved_t  {valid, taken, target[31:0]} from resolver
//  pc               in   32  PC of the branch in ID
//  pred_taken       in   1   prediction carried with the branch from IF
//  pred_target      in   32  predicted target carried from IF
//  ds_valid         in   1   delay-slot instruction of the pending branch is fetched
//  stall_req        out  1   hold ID: FSM not IDLE or update FIFO full
//  redirect_valid   out  1   one-cycle pulse: fetch must load redirect_pc
//  redirect_pc      out  32  corrected fetch PC
//  flush_fetch      out  1   kill IF instructions younger than the delay slot; same cycle as redirect_valid
//  upd_valid        out  1   FIFO head valid (predictor update)
//  upd_ready        in   1   predictor accepts head
//  upd_pc/upd_target out 32  head entry branch PC / resolved target
//  upd_taken        out  1   head entry resolved direction
//  mispredict_cnt   out  32  count of detected mispredicts; wraps at 2^32
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0; FIFO empty; mispredict_cnt=0.
//  accept = resolved_branch.valid & ~stall & ~stall_req & ~except_flush.
//  mispredict = (taken != pred_taken) | (taken & (target != pred_target)).
//  fix_pc = taken ? target : pc + 32'd8, mod 2^32; wrap-around is not an error.
//  FSM states: IDLE, WAIT_DS, REDIRECT.
//   IDLE: accept & mispredict -> latch fix_pc, cnt+1. Then -> REDIRECT if ds_valid, else -> WAIT_DS.
//   WAIT_DS: ds_valid -> REDIRECT.
//   REDIRECT: redirect_valid=flush_fetch=1 for exactly this cycle; redirect_pc=latched fix_pc; -> IDLE.
//   except_flush in any state -> IDLE next cycle, suppressing any pending/current redirect.
//   Latched fix_pc and the FIFO are unaffected by except_flush.
//  Latency: accept at cycle N with ds_valid=1 -> redirect_valid at N+1. Otherwise the redirect comes one cycle after ds_valid rises.
//  redirect_valid is registered (FSM-state decode); never combinational from inputs.
//  Update FIFO:
//   Push {pc, taken, target} on every accept, whether or not it mispredicted.
//   Pop when upd_valid & upd_ready. Outputs show the head entry, registered storage.
//   Push and pop in the same cycle are allowed, full or empty.
//   Full -> stall_req=1, so no push is ever dropped.
//   Full-with-simultaneous-pop still holds stall_req that cycle (conservative).
//   Empty -> upd_valid=0; upd_* data are don't-care.
//   Pointers use DEPTH+1-bit wrap for the full/empty distinction.
//  Async reset mid-WAIT_DS or mid-drain: immediately return to reset values; pending entries are discarded.
// TESTING
//  1. pred_taken=0, taken=1, target=0x8000_0100, ds_valid=1 -> next cycle: redirect_valid=1, redirect_pc=0x8000_0100, cnt=1.
//  2. pred_taken=1, taken=0, pc=0xBFC0_0010, ds_valid=0 for 3 cycles -> stall_req=1, no redirect.
//     ds_valid rises -> redirect_pc=0xBFC0_0018 next cycle.
//  3. Correct prediction (taken, target matches) -> no redirect; FIFO gains 1 entry with the same {pc, taken, target}.
//  4. upd_ready=0, 4 accepted branches -> stall_req=1, 5th not accepted.
//     upd_ready=1 -> entries drain in order; stall_req drops once not full.
//  5. except_flush asserted in WAIT_DS -> no redirect_valid ever pulses; FSM IDLE; cnt keeps its increment.
//  6. pc=0xFFFF_FFFC, not-taken mispredict -> redirect_pc=0x0000_0004 (wrap).
//     Also: rst_n low mid-WAIT_DS -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/branch_redirect_if.sv
// branch_redirect_if: resolver/fetch/predictor signals of the branch redirect unit
package branch_redirect_pkg;
  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [31:0] target;
  } branch_resolved_t;
endpackage

interface branch_redirect_if;
  import branch_redirect_pkg::*;
  logic             stall;
  logic             except_flush;
  branch_resolved_t resolved_branch;
  logic [31:0]      pc;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             ds_valid;
  logic             stall_req;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush_fetch;
  logic             upd_valid;
  logic             upd_ready;
  logic [31:0]      upd_pc;
  logic [31:0]      upd_target;
  logic             upd_taken;
  logic [31:0]      mispredict_cnt;
  modport slave (
    input  stall, except_flush, resolved_branch, pc, pred_taken, pred_target, ds_valid, upd_ready,
    output stall_req, redirect_valid, redirect_pc, flush_fetch, upd_valid, upd_pc, upd_target,
           upd_taken, mispredict_cnt
  );
  modport master (
    output stall, except_flush, resolved_branch, pc, pred_taken, pred_target, ds_valid, upd_ready,
    input  stall_req, redirect_valid, redirect_pc, flush_fetch, upd_valid, upd_pc, upd_target,
           upd_taken, mispredict_cnt
  );
endinterface

// File: rtl/branch_redirect.sv
// branch_redirect: mispredict detection, delay-slot-aware fetch redirect and predictor update FIFO
module branch_redirect
  import branch_redirect_pkg::*;
#(
  parameter int UPD_DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  branch_redirect_if.slave bus
);
  localparam int AW = $clog2(UPD_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT_DS, REDIRECT} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } upd_t;
  state_t      state, state_nx;
  upd_t        mem [UPD_DEPTH];
  logic [AW:0] wp, rp;
  logic [31:0] fix_pc, fix_q, cnt;
  logic        accept, mispredict, full, empty, pop;
  assign mispredict = (bus.resolved_branch.taken != bus.pred_taken) |
                      (bus.resolved_branch.taken & (bus.resolved_branch.target != bus.pred_target));
  assign accept = bus.resolved_branch.valid & ~bus.stall & ~bus.stall_req & ~bus.except_flush;
  assign fix_pc = bus.resolved_branch.taken ? bus.resolved_branch.target : bus.pc + 32'd8;
  assign empty = wp == rp;
  // Extra pointer bit tells a full ring from an empty one
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop = ~empty & bus.upd_ready;
  assign bus.stall_req = (state != IDLE) | full;
  assign bus.redirect_pc = fix_q;
  assign bus.mispredict_cnt = cnt;
  assign bus.upd_valid = ~empty;
  assign bus.upd_pc = mem[rp[AW-1:0]].pc;
  assign bus.upd_taken = mem[rp[AW-1:0]].taken;
  assign bus.upd_target = mem[rp[AW-1:0]].target;
  always_comb begin
    state_nx = state;
    bus.redirect_valid = state == REDIRECT;
    bus.flush_fetch = state == REDIRECT;
    state_nx = bus.except_flush ? IDLE :
               state == IDLE    ? ((accept & mispredict) ? (bus.ds_valid ? REDIRECT : WAIT_DS) : IDLE) :
               state == WAIT_DS ? (bus.ds_valid ? REDIRECT : WAIT_DS) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fix_q <= '0;
      cnt <= '0;
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < UPD_DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nx;
      if (accept & mispredict) begin
        fix_q <= fix_pc;
        cnt <= cnt + 32'd1;
      end
      if (accept) begin
        mem[wp[AW-1:0]] <= '{pc: bus.pc, taken: bus.resolved_branch.taken, target: bus.resolved_branch.target};
        wp <= wp + (AW+1)'(1);
      end
      if (pop) rp <= rp + (AW+1)'(1);
    end
  end
endmodule

// File: tb/tb_branch_redirect.sv
// tb_branch_redirect: directed checks of redirect timing, flush, wrap and update FIFO
module tb_branch_redirect;
  import branch_redirect_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  int n_chk = 0;
  int n_fail = 0;
  branch_redirect_if bi ();
  branch_redirect #(.UPD_DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bi.slave));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bi.stall = 0;
    bi.except_flush = 0;
    bi.resolved_branch = '0;
    bi.pc = 0;
    bi.pred_taken = 0;
    bi.pred_target = 0;
    bi.ds_valid = 0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                       input logic ptk, input logic [31:0] ptg, input logic ds);
    bi.resolved_branch = {1'b1, tk, tg};
    bi.pc = pc;
    bi.pred_taken = ptk;
    bi.pred_target = ptg;
    bi.ds_valid = ds;
  endtask

  task automatic test_reset();
    idle_inputs();
    bi.upd_ready = 0;
    rst_n = 0;
    #3;
    n_chk++; if (bi.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_redirect_valid got %b want 0", bi.redirect_valid); end
    n_chk++; if (bi.flush_fetch !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b want 0", bi.flush_fetch); end
    n_chk++; if (bi.redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect_pc got %h want 0", bi.redirect_pc); end
    n_chk++; if (bi.stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall_req got %b want 0", bi.stall_req); end
    n_chk++; if (bi.upd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_upd_valid got %b want 0", bi.upd_valid); end
    n_chk++; if (bi.mispredict_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_cnt got %h want 0", bi.mispredict_cnt); end
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_taken_mispredict();
    drive(32'h8000_0000, 1, 32'h8000_0100, 0, 32'h0, 1);
    tick();
    idle_inputs();
    n_chk++; if (bi.redirect_valid !== 1'b1) begin n_fail++; $display("FAIL t1_redirect_valid got %b want 1", bi.redirect_valid); end
    n_chk++; if (bi.flush_fetch !== 1'b1) begin n_fail++; $display("FAIL t1_flush got %b want 1", bi.flush_fetch); end
    n_chk++; if (bi.redirect_pc !== 32'h8000_0100) begin n_fail++; $display("FAIL t1_redirect_pc got %h want 80000100", bi.redirect_pc); end
    n_chk++; if (bi.mispredict_cnt !== 32'd1) begin n_fail++; $display("FAIL t1_cnt got %0d want 1", bi.mispredict_cnt); end
    n_chk++; if (bi.upd_pc !== 32'h8000_0000 || bi.upd_taken !== 1'b1 || bi.upd_target !== 32'h8000_0100)
      begin n_fail++; $display("FAIL t1_upd_entry got %h/%b/%h want 80000000/1/80000100", bi.upd_pc, bi.upd_taken, bi.upd_target); end
    tick();
    n_chk++; if (bi.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL t1_pulse_len got %b want 0", bi.redirect_valid); end
    n_chk++; if (bi.stall_req !== 1'b0) begin n_fail++; $display("FAIL t1_stall_after got %b want 0", bi.stall_req); end
    bi.upd_ready = 1;
    tick();
    bi.upd_ready = 0;
    n_chk++; if (bi.upd_valid !== 1'b0) begin n_fail++; $display("FAIL t1_drained got %b want 0", bi.upd_valid); end
  endtask

  task automatic test_wait_ds();
    drive(32'hBFC0_0010, 0, 32'h0000_1234, 1, 32'h0000_1234, 0);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (bi.stall_req !== 1'b1 || bi.redirect_valid !== 1'b0)
        begin n_fail++; $display("FAIL t2_wait%0d stall_req/redirect got %b/%b want 1/0", i, bi.stall_req, bi.redirect_valid); end
      tick();
    end
    bi.ds_valid = 1;
    tick();
    bi.ds_valid = 0;
    n_chk++; if (bi.redirect_valid !== 1'b1) begin n_fail++; $display("FAIL t2_redirect_valid got %b want 1", bi.redirect_valid); end
    n_chk++; if (bi.redirect_pc !== 32'hBFC0_0018) begin n_fail++; $display("FAIL t2_redirect_pc got %h want bfc00018", bi.redirect_pc); end
    n_chk++; if (bi.mispredict_cnt !== 32'd2) begin n_fail++; $display("FAIL t2_cnt got %0d want 2", bi.mispredict_cnt); end
    n_chk++; if (bi.upd_pc !== 32'hBFC0_0010 || bi.upd_taken !== 1'b0)
      begin n_fail++; $display("FAIL t2_upd_entry got %h/%b want bfc00010/0", bi.upd_pc, bi.upd_taken); end
    tick();
    bi.upd_ready = 1;
    tick();
    bi.upd_ready = 0;
  endtask

  task automatic test_correct_prediction();
    drive(32'h0000_0100, 1, 32'h0000_0200, 1, 32'h0000_0200, 1);
    tick();
    idle_inputs();
    n_chk++; if (bi.redirect_valid !== 1'b0 || bi.stall_req !== 1'b0)
      begin n_fail++; $display("FAIL t3_no_redirect redirect/stall got %b/%b want 0/0", bi.redirect_valid, bi.stall_req); end
    n_chk++; if (bi.upd_valid !== 1'b1 || bi.upd_pc !== 32'h100 || bi.upd_taken !== 1'b1 || bi.upd_target !== 32'h200)
      begin n_fail++; $display("FAIL t3_upd_entry got %b %h/%b/%h want 1 100/1/200", bi.upd_valid, bi.upd_pc, bi.upd_taken, bi.upd_target); end
    n_chk++; if (bi.mispredict_cnt !== 32'd2) begin n_fail++; $display("FAIL t3_cnt got %0d want 2", bi.mispredict_cnt); end
    bi.upd_ready = 1;
    tick();
    bi.upd_ready = 0;
    n_chk++; if (bi.upd_valid !== 1'b0) begin n_fail++; $display("FAIL t3_drained got %b want 0", bi.upd_valid); end
  endtask

  task automatic test_fifo_full();
    logic [31:0] exp_pc;
    for (int i = 1; i <= 4; i++) begin
      drive(32'(i * 16), 0, 32'h0, 0, 32'h0, 0);
      tick();
    end
    n_chk++; if (bi.stall_req !== 1'b1) begin n_fail++; $display("FAIL t4_full_stall got %b want 1", bi.stall_req); end
    drive(32'h50, 0, 32'h0, 0, 32'h0, 0);
    tick();
    tick();
    idle_inputs();
    n_chk++; if (bi.stall_req !== 1'b1 || bi.upd_pc !== 32'h10)
      begin n_fail++; $display("FAIL t4_fifth_blocked stall/head got %b/%h want 1/10", bi.stall_req, bi.upd_pc); end
    bi.upd_ready = 1;
    for (int i = 2; i <= 4; i++) begin
      tick();
      exp_pc = 32'(i * 16);
      n_chk++; if (bi.upd_valid !== 1'b1 || bi.upd_pc !== exp_pc || bi.stall_req !== 1'b0)
        begin n_fail++; $display("FAIL t4_drain%0d valid/head/stall got %b/%h/%b want 1/%h/0", i, bi.upd_valid, bi.upd_pc, bi.stall_req, exp_pc); end
    end
    tick();
    bi.upd_ready = 0;
    n_chk++; if (bi.upd_valid !== 1'b0) begin n_fail++; $display("FAIL t4_empty got %b want 0 (fifth entry leaked)", bi.upd_valid); end
    n_chk++; if (bi.mispredict_cnt !== 32'd2) begin n_fail++; $display("FAIL t4_cnt got %0d want 2", bi.mispredict_cnt); end
  endtask

  task automatic test_except_flush();
    drive(32'h0000_3000, 1, 32'h0000_4000, 0, 32'h0, 0);
    tick();
    idle_inputs();
    n_chk++; if (bi.stall_req !== 1'b1) begin n_fail++; $display("FAIL t5_wait_stall got %b want 1", bi.stall_req); end
    bi.except_flush = 1;
    tick();
    bi.except_flush = 0;
    n_chk++; if (bi.stall_req !== 1'b0 || bi.redirect_valid !== 1'b0)
      begin n_fail++; $display("FAIL t5_flushed stall/redirect got %b/%b want 0/0", bi.stall_req, bi.redirect_valid); end
    bi.ds_valid = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_chk++; if (bi.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL t5_no_redirect%0d got %b want 0", i, bi.redirect_valid); end
    end
    bi.ds_valid = 0;
    n_chk++; if (bi.mispredict_cnt !== 32'd3) begin n_fail++; $display("FAIL t5_cnt got %0d want 3", bi.mispredict_cnt); end
    n_chk++; if (bi.redirect_pc !== 32'h4000) begin n_fail++; $display("FAIL t5_fix_pc_kept got %h want 4000", bi.redirect_pc); end
    n_chk++; if (bi.upd_valid !== 1'b1 || bi.upd_pc !== 32'h3000)
      begin n_fail++; $display("FAIL t5_fifo_kept got %b/%h want 1/3000", bi.upd_valid, bi.upd_pc); end
    bi.upd_ready = 1;
    tick();
    bi.upd_ready = 0;
  endtask

  task automatic test_wrap_and_async_reset();
    drive(32'hFFFF_FFFC, 0, 32'h0, 1, 32'h0, 1);
    tick();
    idle_inputs();
    n_chk++; if (bi.redirect_valid !== 1'b1 || bi.redirect_pc !== 32'h0000_0004)
      begin n_fail++; $display("FAIL t6_wrap redirect/pc got %b/%h want 1/00000004", bi.redirect_valid, bi.redirect_pc); end
    n_chk++; if (bi.mispredict_cnt !== 32'd4) begin n_fail++; $display("FAIL t6_cnt got %0d want 4", bi.mispredict_cnt); end
    tick();
    drive(32'h0000_7000, 1, 32'h0000_9000, 0, 32'h0, 0);
    tick();
    idle_inputs();
    n_chk++; if (bi.stall_req !== 1'b1 || bi.upd_valid !== 1'b1)
      begin n_fail++; $display("FAIL t6_pre_reset stall/upd_valid got %b/%b want 1/1", bi.stall_req, bi.upd_valid); end
    #2;
    rst_n = 0;
    #1;
    n_chk++; if (bi.stall_req !== 1'b0 || bi.upd_valid !== 1'b0 || bi.redirect_valid !== 1'b0)
      begin n_fail++; $display("FAIL t6_async_ctl stall/upd/redirect got %b/%b/%b want 0/0/0", bi.stall_req, bi.upd_valid, bi.redirect_valid); end
    n_chk++; if (bi.mispredict_cnt !== 32'h0 || bi.redirect_pc !== 32'h0 || bi.upd_pc !== 32'h0)
      begin n_fail++; $display("FAIL t6_async_data cnt/pc/upd_pc got %h/%h/%h want 0/0/0", bi.mispredict_cnt, bi.redirect_pc, bi.upd_pc); end
    tick();
    rst_n = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_taken_mispredict();
    test_wait_ds();
    test_correct_prediction();
    test_fifo_full();
    test_except_flush();
    test_wrap_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
